// File: rtl/decode_reg_arith_pipe.sv
// decode_reg_arith_pipe: R-type (RV32I / optional RV32M) arithmetic decoder
// with valid/ready input, registered output stage and a one-entry skid buffer.
//
// Ports:
//   clk, rst (async, active-low), flush (sync, highest priority)
//   in_valid/in_ready, in_funct3, in_funct7, in_tag    : decode request
//   out_valid/out_ready, out_kind, out_illegal, out_tag : decoded result
//   illegal_count                                       : saturating count
//                                                         of accepted
//                                                         illegal encodings

package instr_type;
    typedef enum logic [4:0] {
        rak_invalid,
        rak_add,
        rak_sub,
        rak_sll,
        rak_slt,
        rak_sltu,
        rak_xor,
        rak_srl,
        rak_sra,
        rak_or,
        rak_and,
        rak_mul,
        rak_mulh,
        rak_mulhsu,
        rak_mulhu,
        rak_div,
        rak_divu,
        rak_rem,
        rak_remu
    } reg_arith_kind_t;
endpackage

module decode_reg_arith_pipe
    import instr_type::*;
#(
    parameter bit ENABLE_M = 1'b0,
    parameter int TAG_W    = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output reg_arith_kind_t  out_kind,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             out_valid_q,   out_valid_d;
    reg_arith_kind_t  out_kind_q,    out_kind_d;
    logic             out_illegal_q, out_illegal_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;

    logic             skid_valid_q,   skid_valid_d;
    reg_arith_kind_t  skid_kind_q,    skid_kind_d;
    logic             skid_illegal_q, skid_illegal_d;
    logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;

    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    reg_arith_kind_t  dec_kind;
    logic             dec_illegal;
    logic             accept;
    logic             consume;

    // Strict decode: anything not explicitly listed falls through to invalid.
    always_comb begin
        dec_kind = rak_invalid;
        unique case (1'b1)
            (in_funct7 == 7'b0000000): begin
                case (in_funct3)
                    3'b000:  dec_kind = rak_add;
                    3'b001:  dec_kind = rak_sll;
                    3'b010:  dec_kind = rak_slt;
                    3'b011:  dec_kind = rak_sltu;
                    3'b100:  dec_kind = rak_xor;
                    3'b101:  dec_kind = rak_srl;
                    3'b110:  dec_kind = rak_or;
                    default: dec_kind = rak_and;
                endcase
            end
            (in_funct7 == 7'b0100000): begin
                if (in_funct3 == 3'b000) begin
                    dec_kind = rak_sub;
                end else if (in_funct3 == 3'b101) begin
                    dec_kind = rak_sra;
                end
            end
            (in_funct7 == 7'b0000001): begin
                if (ENABLE_M) begin
                    case (in_funct3)
                        3'b000:  dec_kind = rak_mul;
                        3'b001:  dec_kind = rak_mulh;
                        3'b010:  dec_kind = rak_mulhsu;
                        3'b011:  dec_kind = rak_mulhu;
                        3'b100:  dec_kind = rak_div;
                        3'b101:  dec_kind = rak_divu;
                        3'b110:  dec_kind = rak_rem;
                        default: dec_kind = rak_remu;
                    endcase
                end
            end
            default: dec_kind = rak_invalid;
        endcase
    end

    assign dec_illegal = (dec_kind == rak_invalid);
    assign accept      = in_valid && in_ready_q;
    assign consume     = out_valid_q && out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_kind_d     = out_kind_q;
        out_illegal_d  = out_illegal_q;
        out_tag_d      = out_tag_q;
        skid_valid_d   = skid_valid_q;
        skid_kind_d    = skid_kind_q;
        skid_illegal_d = skid_illegal_q;
        skid_tag_d     = skid_tag_q;
        cnt_d          = cnt_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (skid_valid_q) begin
                // in_ready is low here, so no new input can arrive.
                if (consume) begin
                    out_kind_d    = skid_kind_q;
                    out_illegal_d = skid_illegal_q;
                    out_tag_d     = skid_tag_q;
                    skid_valid_d  = 1'b0;
                end
            end else if (accept) begin
                if (!out_valid_q || consume) begin
                    out_valid_d   = 1'b1;
                    out_kind_d    = dec_kind;
                    out_illegal_d = dec_illegal;
                    out_tag_d     = in_tag;
                end else begin
                    skid_valid_d   = 1'b1;
                    skid_kind_d    = dec_kind;
                    skid_illegal_d = dec_illegal;
                    skid_tag_d     = in_tag;
                end
            end else if (consume) begin
                out_valid_d = 1'b0;
            end

            if (accept && dec_illegal && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // Registered ready: high exactly when the skid will be empty.
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_kind_q     <= rak_invalid;
            out_illegal_q  <= 1'b0;
            out_tag_q      <= '0;
            skid_valid_q   <= 1'b0;
            skid_kind_q    <= rak_invalid;
            skid_illegal_q <= 1'b0;
            skid_tag_q     <= '0;
            in_ready_q     <= 1'b1;
            cnt_q          <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_kind_q     <= out_kind_d;
            out_illegal_q  <= out_illegal_d;
            out_tag_q      <= out_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_kind_q    <= skid_kind_d;
            skid_illegal_q <= skid_illegal_d;
            skid_tag_q     <= skid_tag_d;
            in_ready_q     <= in_ready_d;
            cnt_q          <= cnt_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_kind      = out_kind_q;
    assign out_illegal   = out_illegal_q;
    assign out_tag       = out_tag_q;
    assign illegal_count = cnt_q;

endmodule
